// File: rtl/imm_inst_encoder.sv
// ----------------------------------------------------------------------------
// imm_inst_encoder
//   Packs register fields and a 32-bit signed immediate into a RISC-V
//   instruction word (I/S/B/J/R layouts). It is the inverse of an immediate
//   generator and is used by the loader/self-test path that fills instruction
//   memory. Each accepted word is tagged with an auto-incrementing byte
//   address and queued in a 2-entry output FIFO.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   addr_load/_value    load the address counter (bits [1:0] forced to 0)
//   in_valid/in_ready   request handshake
//   in_opcode..in_imm   instruction fields and signed immediate
//   out_valid/out_ready FIFO head handshake
//   out_inst/addr/err   FIFO head: word, byte address, {opc,align,range} flags
//   err_cnt             saturating count of accepted requests with any flag
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
//   both high. Valid must not depend on ready. in_ready depends only on the
//   FIFO occupancy and addr_load; out_valid is purely registered.
// ----------------------------------------------------------------------------
module imm_inst_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_value,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [2:0]        in_funct3,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic [2:0]        out_err,
    output logic [7:0]        err_cnt
);

    // ------------------------------------------------------------------
    // Encoder (combinational)
    // ------------------------------------------------------------------
    logic        w_is_i, w_is_s, w_is_b, w_is_j, w_is_r;
    logic [31:0] w_inst;
    logic        w_range_err, w_align_err, w_opc_err;
    logic [2:0]  w_err;

    always_comb begin
        w_is_i = (in_opcode == 7'b0000011) || (in_opcode == 7'b1100111) ||
                 (in_opcode == 7'b0010011);
        w_is_s = (in_opcode == 7'b0100011);
        w_is_b = (in_opcode == 7'b1100011);
        w_is_j = (in_opcode == 7'b1101111);
        w_is_r = (in_opcode == 7'b0110011);

        w_range_err = 1'b0;
        w_align_err = 1'b0;
        w_opc_err   = !(w_is_i || w_is_s || w_is_b || w_is_j || w_is_r);

        // Range checks: the bits above the encodable field must be a pure
        // sign extension (all zeros or all ones).
        if (w_is_i) begin
            w_inst      = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            w_range_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
        end else if (w_is_s) begin
            w_inst      = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:0], in_opcode};
            w_range_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
        end else if (w_is_b) begin
            w_inst      = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], in_opcode};
            w_range_err = !((&in_imm[31:12]) || !(|in_imm[31:12]));
            w_align_err = in_imm[0];
        end else if (w_is_j) begin
            w_inst      = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                           in_rd, in_opcode};
            w_range_err = !((&in_imm[31:20]) || !(|in_imm[31:20]));
            w_align_err = in_imm[0];
        end else begin
            // R layout, also used for unknown opcodes; immediate ignored.
            w_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        end

        w_err = {w_opc_err, w_align_err, w_range_err};
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic [1:0]        r_count;
    logic              w_push, w_pop;
    logic [ADDR_W-1:0] w_load_val;

    assign in_ready   = (r_count != 2'd2) && !addr_load;
    assign out_valid  = (r_count != 2'd0);
    assign w_push     = in_valid && in_ready;
    assign w_pop      = out_valid && out_ready;
    // Clear the two byte-offset bits so the counter stays word aligned.
    assign w_load_val = addr_value & ~ADDR_W'(3);

    // ------------------------------------------------------------------
    // FIFO: slot 0 is the head and drives the outputs directly; slot 1
    // only ever holds the second-oldest entry.
    // ------------------------------------------------------------------
    logic [31:0]       r_inst0, r_inst1;
    logic [ADDR_W-1:0] r_addr0, r_addr1;
    logic [2:0]        r_err0,  r_err1;
    logic [ADDR_W-1:0] r_addr_cnt;
    logic [7:0]        r_err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= 2'd0;
            r_inst0    <= '0;
            r_addr0    <= BASE_ADDR;
            r_err0     <= '0;
            r_inst1    <= '0;
            r_addr1    <= BASE_ADDR;
            r_err1     <= '0;
            r_addr_cnt <= BASE_ADDR;
            r_err_cnt  <= '0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        r_inst0 <= w_inst;
                        r_addr0 <= r_addr_cnt;
                        r_err0  <= w_err;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        // Head leaves as the new word arrives: it becomes head.
                        r_inst0 <= w_inst;
                        r_addr0 <= r_addr_cnt;
                        r_err0  <= w_err;
                    end else if (w_push) begin
                        r_inst1 <= w_inst;
                        r_addr1 <= r_addr_cnt;
                        r_err1  <= w_err;
                        r_count <= 2'd2;
                    end else if (w_pop) begin
                        r_count <= 2'd0;
                    end
                end
                default: begin
                    // Full: no push possible, a pop shifts slot 1 forward.
                    if (w_pop) begin
                        r_inst0 <= r_inst1;
                        r_addr0 <= r_addr1;
                        r_err0  <= r_err1;
                        r_count <= 2'd1;
                    end
                end
            endcase

            if (addr_load) begin
                r_addr_cnt <= w_load_val;
            end else if (w_push) begin
                r_addr_cnt <= r_addr_cnt + ADDR_W'(4);
            end

            if (w_push && (w_err != 3'b000) && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign out_inst = r_inst0;
    assign out_addr = r_addr0;
    assign out_err  = r_err0;
    assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_imm_inst_encoder.sv
module tb_imm_inst_encoder;

  logic        clk;
  logic        rst;
  logic        addr_load;
  logic [31:0] addr_value;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic [2:0]  out_err;
  logic [7:0]  err_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  imm_inst_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .addr_load  (addr_load),
    .addr_value (addr_value),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_rd      (in_rd),
    .in_funct3  (in_funct3),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_inst   (out_inst),
    .out_addr   (out_addr),
    .out_err    (out_err),
    .err_cnt    (err_cnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vectors ----------------
  typedef struct {
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] inst;
    logic [2:0]  err;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(logic [6:0] opc, logic [4:0] rd, logic [2:0] f3,
                              logic [4:0] rs1, logic [4:0] rs2, logic [6:0] f7,
                              logic [31:0] imm, logic [31:0] inst, logic [2:0] err);
    vec_t v;
    v.opc = opc; v.rd = rd; v.f3 = f3; v.rs1 = rs1; v.rs2 = rs2; v.f7 = f7;
    v.imm = imm; v.inst = inst; v.err = err;
    return v;
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input logic [6:0] opc, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] f7,
                         input logic [31:0] imm);
    in_opcode = opc; in_rd = rd; in_funct3 = f3;
    in_rs1 = rs1; in_rs2 = rs2; in_funct7 = f7; in_imm = imm;
  endtask

  // Presents a request and returns 1 ns after the accepting edge.
  task automatic send(input logic [6:0] opc, input logic [4:0] rd, input logic [2:0] f3,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] f7,
                      input logic [31:0] imm);
    int k;
    @(negedge clk);
    set_req(opc, rd, f3, rs1, rs2, f7, imm);
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      check("send_timeout", 32'(in_ready), 32'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // immediate generator used to check the encoder from the other direction
  function automatic logic [31:0] decode_imm(input logic [6:0] opc, input logic [31:0] i);
    case (opc)
      7'b0100011: decode_imm = {{20{i[31]}}, i[31:25], i[11:7]};
      7'b1100011: decode_imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      7'b1101111: decode_imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:    decode_imm = {{20{i[31]}}, i[31:20]};
    endcase
  endfunction

  // ---------------- stimulus ----------------
  logic [31:0] exp_addr;
  logic [7:0]  exp_err_cnt;

  initial begin
    rst = 1'b1; addr_load = 1'b0; addr_value = '0; in_valid = 1'b0; out_ready = 1'b1;
    set_req('0, '0, '0, '0, '0, '0, '0);

    vecs[0]  = mk(7'b0010011, 5'd1, 3'd0, 5'd2, 5'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF10093, 3'b000);
    vecs[1]  = mk(7'b1100011, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'hFFFF_FFFC, 32'hFE208EE3, 3'b000);
    vecs[2]  = mk(7'b1100011, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd3,         32'h00208163, 3'b010);
    vecs[3]  = mk(7'b1100011, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd4096,      32'h80208063, 3'b001);
    vecs[4]  = mk(7'b1101111, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h0000_0800, 32'h001000EF, 3'b000);
    vecs[5]  = mk(7'b0100011, 5'd0, 3'd2, 5'd3, 5'd4, 7'd0, 32'd8,         32'h0041A423, 3'b000);
    vecs[6]  = mk(7'b0110011, 5'd5, 3'd0, 5'd6, 5'd7, 7'h20, 32'h0001_2345, 32'h407302B3, 3'b000);
    vecs[7]  = mk(7'b1111111, 5'd1, 3'd1, 5'd1, 5'd1, 7'd1, 32'd0,         32'h021090FF, 3'b100);
    vecs[8]  = mk(7'b0000011, 5'd2, 3'd2, 5'd3, 5'd0, 7'd0, 32'h0000_0800, 32'h8001A103, 3'b001);
    vecs[9]  = mk(7'b1101111, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'h0010_0001, 32'h8000006F, 3'b011);
    vecs[10] = mk(7'b1100111, 5'd0, 3'd0, 5'd1, 5'd0, 7'd0, 32'hFFFF_F800, 32'h80008067, 3'b000);

    // reset values while reset is held
    #12;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_inst",  out_inst,       32'd0);
    check("rst_out_addr",  out_addr,       32'd0);
    check("rst_out_err",   32'(out_err),   32'd0);
    check("rst_err_cnt",   32'(err_cnt),   32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ---- table-driven encoding ----
    exp_addr = 32'd0;
    exp_err_cnt = 8'd0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      check("pre_empty", 32'(out_valid), 32'd0);
      send(vecs[i].opc, vecs[i].rd, vecs[i].f3, vecs[i].rs1, vecs[i].rs2, vecs[i].f7, vecs[i].imm);
      if (vecs[i].err != 3'b000) exp_err_cnt = exp_err_cnt + 8'd1;
      check("vec_valid",   32'(out_valid), 32'd1);
      check("vec_inst",    out_inst,       vecs[i].inst);
      check("vec_addr",    out_addr,       exp_addr);
      check("vec_err",     32'(out_err),   32'(vecs[i].err));
      check("vec_err_cnt", 32'(err_cnt),   32'(exp_err_cnt));
      exp_addr = exp_addr + 32'd4;
      @(posedge clk);
      #1;
      check("vec_popped", 32'(out_valid), 32'd0);
    end

    // ---- backpressure: 3 pushes into a 2-deep FIFO ----
    do_reset();
    out_ready = 1'b0;
    send(7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1);
    check("bp_ready_after1", 32'(in_ready), 32'd1);
    send(7'b0010011, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2);
    check("bp_ready_after2", 32'(in_ready), 32'd0);
    check("bp_head_inst",    out_inst,      32'h00100093);
    check("bp_head_addr",    out_addr,      32'd0);
    @(negedge clk);
    set_req(7'b0010011, 5'd3, 3'd0, 5'd0, 5'd0, 7'd0, 32'd3);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_w1_inst",  out_inst,      32'h00200113);
    check("bp_w1_addr",  out_addr,      32'd4);
    check("bp_ready_fr", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_w2_inst",  out_inst,       32'h00300193);
    check("bp_w2_addr",  out_addr,       32'd8);
    check("bp_w2_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    check("bp_drained",  32'(out_valid), 32'd0);

    // ---- addr_load priority and wrap ----
    @(negedge clk);
    addr_load = 1'b1;
    addr_value = 32'hFFFF_FFFE;
    set_req(7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1);
    in_valid = 1'b1;
    #1;
    check("ld_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("ld_no_accept", 32'(out_valid), 32'd0);
    @(negedge clk);
    addr_load = 1'b0;
    @(posedge clk);
    #1;
    check("ld_w0_valid", 32'(out_valid), 32'd1);
    check("ld_w0_addr",  out_addr,       32'hFFFF_FFFC);
    check("ld_w0_inst",  out_inst,       32'h00100093);
    @(negedge clk);
    set_req(7'b0010011, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("ld_w1_addr",  out_addr,       32'h0000_0000);
    check("ld_w1_inst",  out_inst,       32'h00200113);
    @(posedge clk);
    #1;
    check("ld_drained",  32'(out_valid), 32'd0);

    // ---- reset with the FIFO full ----
    out_ready = 1'b0;
    send(7'b1111111, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
    send(7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1);
    check("full_ready",   32'(in_ready), 32'd0);
    check("full_err_cnt", 32'(err_cnt),  32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_valid",   32'(out_valid), 32'd0);
    check("mid_rst_ready",   32'(in_ready),  32'd1);
    check("mid_rst_err_cnt", 32'(err_cnt),   32'd0);
    check("mid_rst_inst",    out_inst,       32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;

    // ---- round trip through an immediate generator ----
    for (int n = 0; n < 1000; n++) begin
      logic [6:0]  opc;
      logic [31:0] r;
      logic [31:0] imm;
      r = $urandom;
      case ($urandom_range(0, 3))
        0: begin opc = 7'b0010011; imm = {{20{r[11]}}, r[11:0]}; end
        1: begin opc = 7'b0100011; imm = {{20{r[11]}}, r[11:0]}; end
        2: begin opc = 7'b1100011; imm = {{19{r[12]}}, r[12:1], 1'b0}; end
        default: begin opc = 7'b1101111; imm = {{11{r[20]}}, r[20:1], 1'b0}; end
      endcase
      send(opc, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           7'($urandom_range(0, 127)), imm);
      check("rt_imm", decode_imm(opc, out_inst), imm);
      check("rt_err", 32'(out_err), 32'd0);
    end

    // ---- err_cnt saturation ----
    do_reset();
    for (int n = 0; n < 257; n++) begin
      send(7'b1111111, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
    end
    check("err_cnt_sat", 32'(err_cnt), 32'd255);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
